serdes_rx_packer: RTL
=====================

Name: serdes_rx_packer

Overview:
- Downstream consumer of the ECC serdes output stream. That stream is valid-only: one DATA_WIDTH word per asserted valid, with no backpressure.
- Packs WORDS_PER_BEAT consecutive words into one wide beat. Presents beats on a valid/ready interface through a 2-entry output buffer.
- Drops beats and raises a sticky overflow flag when the sink stalls too long.
- flush_i emits a partial beat with a keep mask.

Parameters:
- DATA_WIDTH, 8, width of each incoming word (matches serdes parallel_out_o).
- WORDS_PER_BEAT, 4, words per output beat; legal range 2..16.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset, asynchronous, active-low
- data_i  input  DATA_WIDTH  word from serdes parallel_out_o
- valid_i  input  1  data_i valid this cycle (serdes valid_out_o); no ready returned
- flush_i  input  1  close the current partial beat
- data_o  output  DATA_WIDTH*WORDS_PER_BEAT  packed beat
- keep_o  output  WORDS_PER_BEAT  per-word valid mask of data_o
- valid_o  output  1  beat available
- ready_i  input  1  sink accepts beat
- overflow_o  output  1  sticky: at least one beat was dropped
- fill_o  output  $clog2(WORDS_PER_BEAT+1)  words held in the assembly register

Behaviour:
- Reset (rst_n_i low, asynchronous): valid_o=0, data_o=0, keep_o=0, overflow_o=0, fill_o=0. Output buffer empties and the assembly register clears. An in-progress beat is discarded without being emitted.
- Word order is little-endian:
  - The first word of a beat lands in data_o[DATA_WIDTH-1:0] and sets keep_o[0].
  - Word k lands in slice k and sets keep_o[k].
  - keep_o is always a contiguous run of ones from bit 0.
- Assembly: each valid_i writes data_i into slot fill_q and increments fill_q.
- A beat closes in either of these cases:
  - fill_q reaches WORDS_PER_BEAT (full beat, keep all ones).
  - flush_i is high and (fill_q>0 or valid_i). The partial beat includes the word arriving this cycle, and unused slots are zero.
- valid_i and flush_i in the same cycle: the word is included first, then the beat closes.
- flush_i with fill_q==0 and valid_i low is a no-op.
- On close, fill_q returns to 0 on the next edge. A word arriving in the cycle after close goes to slot 0.
- Output buffer: 2-entry FIFO of {data, keep}.
  - Push happens on beat close. Pop happens when valid_o && ready_i.
  - Push is accepted if the buffer is not full, or if a pop happens in the same cycle. Simultaneous push and pop keeps the occupancy unchanged.
  - Push into a full buffer with no pop: the beat is dropped, overflow_o goes to 1 on the next edge and stays 1 until reset, and the buffer contents are unchanged.
- Latency: a beat closing on edge N is presented on valid_o/data_o/keep_o after edge N, i.e. one cycle from the last word to valid_o.
- data_o and keep_o always show the FIFO head. They are held stable while valid_o && !ready_i. They are 0 when the buffer is empty.
- Ordering: beats emerge in close order and are never reordered or duplicated.
- Throughput: with ready_i held high, sustains one word per cycle indefinitely with no drops.
- All control logic is registered; valid_o does not combinationally depend on ready_i.

Optional Feature:
- Macro: SERDES_RX_PACKER_STATS_EN.
- When defined, two extra output ports are added:
  - beats_o, 16 bits: counts accepted pops (valid_o && ready_i).
  - dropped_o, 16 bits: counts dropped beats.
  - Both reset to 0, saturate at 16'hFFFF, and update on the edge after the event.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan (DATA_WIDTH=8, WORDS_PER_BEAT=4):
- Reset mid-beat: feed 2 words, assert rst_n_i low asynchronously -> fill_o=0, valid_o=0 immediately. The next 4 words 0x10..0x13 produce data_o=0x13121110.
- Full beat, ready_i=1: words 0x01,0x02,0x03,0x04 on 4 consecutive cycles -> one cycle after 0x04, valid_o=1, data_o=0x04030201, keep_o=4'b1111.
- Flush with word: words 0xAA, then 0xBB with flush_i high in the same cycle -> data_o=0x0000BBAA, keep_o=4'b0011. The next word 0xCC starts a new beat in slot 0.
- Backpressure and overflow: ready_i=0, stream 12 words 0x00..0x0B -> first two beats buffered, third beat dropped, overflow_o=1. Then raise ready_i -> 0x03020100 then 0x07060504, overflow_o stays 1.
- Push with simultaneous pop while full: buffer full, ready_i=1 on the cycle a third beat closes -> no drop, overflow_o=0, three beats delivered in order.
- Idle flush: flush_i pulsed with fill_o=0 and valid_i=0 -> no beat emitted, valid_o stays 0. With the macro defined, beats_o and dropped_o are checked after the overflow scenario: 2 and 1.

Source files
------------

// File: rtl/serdes_rx_packer.sv
// serdes_rx_packer
//   Packs WORDS_PER_BEAT consecutive DATA_WIDTH words from the valid-only
//   serdes stream into one wide beat. Word 0 goes in the least-significant
//   slice. Beats are presented through a 2-entry valid/ready output buffer.
//   A beat that closes while the buffer is full and not draining is dropped,
//   and the sticky overflow flag is set.
//
// Ports
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   data_i/valid_i  incoming word stream (no backpressure)
//   flush_i         close the current partial beat (keep_o marks used words)
//   data_o/keep_o   buffer head beat and its word mask (0 when empty)
//   valid_o/ready_i output handshake
//   overflow_o      sticky flag: at least one beat was dropped
//   fill_o          words currently held in the assembly register
//
// Optional feature (macro SERDES_RX_PACKER_STATS_EN)
//   beats_o   saturating count of accepted pops
//   dropped_o saturating count of dropped beats
module serdes_rx_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int WORDS_PER_BEAT = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic [DATA_WIDTH-1:0]                   data_i,
    input  logic                                    valid_i,
    input  logic                                    flush_i,
    output logic [DATA_WIDTH*WORDS_PER_BEAT-1:0]    data_o,
    output logic [WORDS_PER_BEAT-1:0]               keep_o,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic                                    overflow_o,
`ifdef SERDES_RX_PACKER_STATS_EN
    output logic [15:0]                             beats_o,
    output logic [15:0]                             dropped_o,
`endif
    output logic [$clog2(WORDS_PER_BEAT+1)-1:0]     fill_o
);

    localparam int FW = $clog2(WORDS_PER_BEAT + 1);
    localparam int BW = DATA_WIDTH * WORDS_PER_BEAT + WORDS_PER_BEAT;

    logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0] asm_q;
    logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0] beat_data;
    logic [WORDS_PER_BEAT-1:0]                 beat_keep;
    logic [FW-1:0]                             fill_q;
    logic [FW-1:0]                             words_in;
    logic                                      close;

    logic [1:0][BW-1:0] mem_q;
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;
    logic               overflow_q;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // Assembly register merged with this cycle's word; the beat that closes
    // therefore already contains the word arriving on the closing cycle.
    always_comb begin
        beat_data = asm_q;
        beat_keep = '0;
        words_in  = fill_q + FW'(valid_i);
        for (int unsigned k = 0; k < WORDS_PER_BEAT; k++) begin
            if (valid_i && fill_q == FW'(k)) begin
                beat_data[k] = data_i;
            end
            beat_keep[k] = (FW'(k) < words_in);
        end
        close = (valid_i && fill_q == FW'(WORDS_PER_BEAT - 1)) ||
                (flush_i && (fill_q != '0 || valid_i));
    end

    always_comb begin
        pop     = (count_q != 2'd0) && ready_i;
        push_ok = close && ((count_q != 2'd2) || pop);
        drop    = close && !push_ok;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            asm_q      <= '0;
            fill_q     <= '0;
            mem_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            // Cleared on close so unused slots of the next partial beat are zero.
            if (close) begin
                asm_q  <= '0;
                fill_q <= '0;
            end else if (valid_i) begin
                asm_q  <= beat_data;
                fill_q <= words_in;
            end

            if (push_ok) begin
                mem_q[wr_ptr_q] <= {beat_keep, beat_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef SERDES_RX_PACKER_STATS_EN
    logic [15:0] beats_q;
    logic [15:0] dropped_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beats_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (pop && beats_q != '1) begin
                beats_q <= beats_q + 16'd1;
            end
            if (drop && dropped_q != '1) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    assign beats_o   = beats_q;
    assign dropped_o = dropped_q;
`endif

    assign valid_o           = (count_q != 2'd0);
    assign {keep_o, data_o}  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o        = overflow_q;
    assign fill_o            = fill_q;

endmodule
